// File: rtl/batch_norm_controller_pkg.sv
// Shared types and defaults for the batch-norm controller and its datapath.
// Defines package bn_pkg: the controller state enum and parameter defaults.
package bn_pkg;

    localparam int BN_DATA_WIDTH = 32;
    localparam int BN_PE_LATENCY = 3;
    localparam int BN_FILTERS    = 64;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        OUT,
        DONE
    } bn_state_e;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/batch_norm_controller_if.sv
// Bus bundle between the batch-norm controller and its neighbours: start/status,
// parameter memory port, input tile handshake, datapath controls and result handshake.
interface batch_norm_controller_if
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = BN_DATA_WIDTH,
    parameter int FILTERS    = BN_FILTERS
) ();

    localparam int CH_W = ch_width(FILTERS);

    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  param_rd_o;
    logic [CH_W-1:0]       param_addr_o;
    logic [DATA_WIDTH-1:0] param_gamma_i;
    logic [DATA_WIDTH-1:0] param_mean_i;
    logic [DATA_WIDTH-1:0] param_denom_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  bn_en_o;
    logic [DATA_WIDTH-1:0] bn_gamma_o;
    logic [DATA_WIDTH-1:0] bn_mean_o;
    logic [DATA_WIDTH-1:0] bn_denom_o;
    logic [CH_W-1:0]       channel_o;
    logic                  result_valid_o;
    logic                  result_ready_i;

    modport master (
        output start_i, param_gamma_i, param_mean_i, param_denom_i,
               in_valid_i, result_ready_i,
        input  busy_o, done_o, param_rd_o, param_addr_o, in_ready_o, bn_en_o,
               bn_gamma_o, bn_mean_o, bn_denom_o, channel_o, result_valid_o
    );

    modport slave (
        input  start_i, param_gamma_i, param_mean_i, param_denom_i,
               in_valid_i, result_ready_i,
        output busy_o, done_o, param_rd_o, param_addr_o, in_ready_o, bn_en_o,
               bn_gamma_o, bn_mean_o, bn_denom_o, channel_o, result_valid_o
    );

endinterface

// File: rtl/batch_norm_controller_param_regs.sv
// Holding registers for gamma/mean/denominator broadcast to the BN element array.
// With BN_CTRL_PREFETCH_EN a shadow set captures the next channel's words early.
module bn_param_regs
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = BN_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_i,
`ifdef BN_CTRL_PREFETCH_EN
    input  logic                  prefetch_i,
    input  logic                  swap_i,
`endif
    input  logic [DATA_WIDTH-1:0] gamma_i,
    input  logic [DATA_WIDTH-1:0] mean_i,
    input  logic [DATA_WIDTH-1:0] denom_i,
    output logic [DATA_WIDTH-1:0] gamma_o,
    output logic [DATA_WIDTH-1:0] mean_o,
    output logic [DATA_WIDTH-1:0] denom_o
);

    localparam int SET_W = 3 * DATA_WIDTH;

    logic [SET_W-1:0] fetched;
    logic [SET_W-1:0] param_d, param_q;

    assign fetched = {gamma_i, mean_i, denom_i};

`ifdef BN_CTRL_PREFETCH_EN
    logic [SET_W-1:0] shadow_d, shadow_q;
    logic             cap_d, cap_q;

    // Memory data lags the read by one cycle; a swap landing on that cycle takes it directly.
    always_comb begin
        param_d  = param_q;
        shadow_d = shadow_q;
        cap_d    = prefetch_i;
        if (load_i) param_d = fetched;
        if (cap_q) shadow_d = fetched;
        if (swap_i) param_d = cap_q ? fetched : shadow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            param_q  <= '0;
            shadow_q <= '0;
            cap_q    <= 1'b0;
        end else begin
            param_q  <= param_d;
            shadow_q <= shadow_d;
            cap_q    <= cap_d;
        end
    end
`else
    always_comb begin
        param_d = param_q;
        if (load_i) param_d = fetched;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) param_q <= '0;
        else          param_q <= param_d;
    end
`endif

    assign {gamma_o, mean_o, denom_o} = param_q;

endmodule

// File: rtl/batch_norm_controller.sv
// Channel sequencer for the batch-norm datapath: fetch params, launch one tile, drain result.
// Optional macro BN_CTRL_PREFETCH_EN overlaps the next channel's parameter fetch with WAIT.
module batch_norm_controller
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = BN_DATA_WIDTH,
    parameter int FILTERS    = BN_FILTERS,
    parameter int PE_LATENCY = BN_PE_LATENCY
) (
    input logic                   clk,
    input logic                   reset_n,
    batch_norm_controller_if.slave bus
);

    localparam int              CH_W     = ch_width(FILTERS);
    localparam int              LAT_W    = ch_width(PE_LATENCY);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(FILTERS - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PE_LATENCY - 1);

    bn_state_e        state_d, state_q;
    logic [CH_W-1:0]  chan_d, chan_q;
    logic [LAT_W-1:0] lat_d, lat_q;
    logic             load;
    logic             last_ch;

    assign last_ch = (chan_q == LAST_CH);

`ifdef BN_CTRL_PREFETCH_EN
    logic prefetch;
    logic swap;
`endif

    always_comb begin
        state_d            = state_q;
        chan_d             = chan_q;
        lat_d              = lat_q;
        load               = 1'b0;
`ifdef BN_CTRL_PREFETCH_EN
        prefetch           = 1'b0;
        swap               = 1'b0;
`endif
        bus.busy_o         = (state_q != IDLE) && (state_q != DONE);
        bus.done_o         = 1'b0;
        bus.param_rd_o     = 1'b0;
        bus.param_addr_o   = chan_q;
        bus.in_ready_o     = 1'b0;
        bus.bn_en_o        = 1'b0;
        bus.result_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = FETCH;
                    chan_d  = '0;
                end
            end
            FETCH: begin
                bus.param_rd_o = 1'b1;
                state_d        = LOAD;
            end
            LOAD: begin
                load    = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) begin
                    bus.bn_en_o = 1'b1;
                    lat_d       = LAT_INIT;
                    state_d     = WAIT;
                end
            end
            // The counter runs PE_LATENCY-1 down to 0, one WAIT cycle per step.
            WAIT: begin
                if (lat_q == '0) state_d = OUT;
                else             lat_d   = lat_q - 1'b1;
`ifdef BN_CTRL_PREFETCH_EN
                if ((lat_q == LAT_INIT) && !last_ch) begin
                    prefetch         = 1'b1;
                    bus.param_rd_o   = 1'b1;
                    bus.param_addr_o = chan_q + 1'b1;
                end
`endif
            end
            OUT: begin
                bus.result_valid_o = 1'b1;
                if (bus.result_ready_i) begin
                    if (last_ch) begin
                        state_d = DONE;
                    end else begin
                        chan_d = chan_q + 1'b1;
`ifdef BN_CTRL_PREFETCH_EN
                        swap    = 1'b1;
                        state_d = ISSUE;
`else
                        state_d = FETCH;
`endif
                    end
                end
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            chan_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            lat_q   <= lat_d;
        end
    end

    assign bus.channel_o = chan_q;

    bn_param_regs #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_param_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load),
`ifdef BN_CTRL_PREFETCH_EN
        .prefetch_i (prefetch),
        .swap_i     (swap),
`endif
        .gamma_i    (bus.param_gamma_i),
        .mean_i     (bus.param_mean_i),
        .denom_i    (bus.param_denom_i),
        .gamma_o    (bus.bn_gamma_o),
        .mean_o     (bus.bn_mean_o),
        .denom_o    (bus.bn_denom_o)
    );

endmodule
